// File: rtl/seg_display_scanner.sv
// Time-multiplexed scanner for a 5-digit common-anode seven-segment display.
// Glyphs go through a shadow bank and are committed to the live bank only at frame boundaries.
module seg_display_scanner #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_update,
    input  logic [6:0] i_seg_first,
    input  logic [6:0] i_seg_second,
    input  logic [6:0] i_seg_third,
    input  logic [6:0] i_seg_fourth,
    input  logic [6:0] i_seg_fifth,
    output logic [6:0] o_seg,
    output logic [4:0] o_an,
    output logic       o_frame_done,
    output logic       o_pending
);
    localparam int NUM_DIGITS = 5;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [DW-1:0]                 div_cnt;
    logic [2:0]                    idx;
    logic [NUM_DIGITS-1:0][6:0]    seg_in, shadow, live;
    logic                          pending;
    logic                          slot_end, boundary, commit_now, idx_bad, in_guard;

    assign seg_in     = {i_seg_fifth, i_seg_fourth, i_seg_third, i_seg_second, i_seg_first};
    assign idx_bad    = (idx > IDX_LAST);
    assign slot_end   = (div_cnt == DIV_LAST);
    assign boundary   = i_enable && slot_end && (idx == IDX_LAST);
    // Disabling acts like a frame boundary for the banks: anything waiting lands in live.
    assign commit_now = !i_enable || boundary;
    assign o_pending  = pending;

    generate
        if (BLANK_CYCLES > 0) begin : g_guard
            localparam logic [DW-1:0] BLANK_W = DW'(BLANK_CYCLES);
            assign in_guard = (div_cnt < BLANK_W);
        end else begin : g_no_guard
            assign in_guard = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (!i_enable || idx_bad) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_seg        <= 7'h7f;
            o_an         <= 5'h1f;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= boundary;
            if (!i_enable || idx_bad || in_guard) begin
                o_seg <= 7'h7f;
                o_an  <= 5'h1f;
            end else begin
                o_seg <= live[idx];
                o_an  <= ~(5'b00001 << idx);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow  <= '1;
            live    <= '1;
            pending <= 1'b0;
        end else begin
            if (i_update)
                shadow <= seg_in;
            if (commit_now) begin
                // A strobe in the commit cycle bypasses the shadow bank.
                if (i_update)
                    live <= seg_in;
                else if (pending)
                    live <= shadow;
                pending <= 1'b0;
            end else if (i_update) begin
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: frame-position reference model checked every cycle,
// plus table-driven glyph loads and hand-written reset/disable sequences.
module tb_seg_display_scanner;
    localparam int CLK_DIV = 4;
    localparam int BLANK   = 1;
    localparam int FRAME   = 5 * CLK_DIV;

    logic             clk = 1'b0;
    logic             rst, en, upd;
    logic [4:0][6:0]  seg_in;
    logic [6:0]       o_seg;
    logic [4:0]       o_an;
    logic             o_frame_done, o_pending;

    always #5 clk = ~clk;

    seg_display_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_update(upd),
        .i_seg_first(seg_in[0]), .i_seg_second(seg_in[1]), .i_seg_third(seg_in[2]),
        .i_seg_fourth(seg_in[3]), .i_seg_fifth(seg_in[4]),
        .o_seg(o_seg), .o_an(o_an), .o_frame_done(o_frame_done), .o_pending(o_pending)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: t = cycles since the scan (re)started; position in frame is t mod FRAME.
    int              t;
    logic [4:0][6:0] m_live, m_shadow;
    bit              m_pend;
    logic [6:0]      e_seg;
    logic [4:0]      e_an;
    logic            e_fd, e_pend;

    typedef struct {
        logic [4:0][6:0] glyphs;
        int              offset;
        logic            exp_pend;
        logic [4:0][6:0] exp_seg;
    } vec_t;
    vec_t vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int pos, dig, ph;
        if (rst) begin
            t = 0; m_pend = 0; m_live = '1; m_shadow = '1;
            e_seg = 7'h7f; e_an = 5'h1f; e_fd = 0;
        end else begin
            pos  = t % FRAME;
            dig  = pos / CLK_DIV;
            ph   = pos % CLK_DIV;
            e_fd = en && (pos == FRAME - 1);
            e_seg = 7'h7f; e_an = 5'h1f;
            if (en && ph >= BLANK) begin
                e_an[dig] = 1'b0;
                e_seg     = m_live[dig];
            end
            if (!en || e_fd) begin
                if (upd) m_live = seg_in;
                else if (m_pend) m_live = m_shadow;
                m_pend = 0;
            end else if (upd) begin
                m_pend = 1;
            end
            if (upd) m_shadow = seg_in;
            t = en ? t + 1 : 0;
        end
        e_pend = m_pend;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk); #1;
        chk("model_seg", o_seg, e_seg);
        chk("model_an", o_an, e_an);
        chk("model_frame_done", o_frame_done, e_fd);
        chk("model_pending", o_pending, e_pend);
        chk("an_onehot", $countones(~o_an) <= 1, 1);
    endtask

    task automatic wait_fd();
        bit seen = 0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            cyc();
            if (o_frame_done) seen = 1;
        end
        if (!seen) chk("frame_done_timeout", 0, 1);
    endtask

    // Called right after a frame_done: checks one whole frame against a glyph set.
    task automatic capture_frame(input string name, input logic [4:0][6:0] exp);
        int d;
        logic [4:0] an_exp;
        for (int k = 0; k < FRAME; k++) begin
            cyc();
            d = k / CLK_DIV;
            an_exp = 5'h1f;
            if (k % CLK_DIV >= BLANK) an_exp[d] = 1'b0;
            chk({name, "_an"}, o_an, an_exp);
            chk({name, "_seg"}, o_seg, (k % CLK_DIV >= BLANK) ? exp[d] : 7'h7f);
            chk({name, "_fd_period"}, o_frame_done, k == FRAME - 1);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        wait_fd();
        repeat (v.offset) cyc();
        seg_in = v.glyphs; upd = 1;
        cyc();
        upd = 0; seg_in = 35'({$urandom(), $urandom()});
        chk($sformatf("vec%0d_pending", n), o_pending, v.exp_pend);
        if (v.exp_pend) wait_fd();
        else chk($sformatf("vec%0d_bypass_fd", n), o_frame_done, 1);
        capture_frame($sformatf("vec%0d", n), v.exp_seg);
    endtask

    logic [4:0][6:0] g_lw, g_sw, g_dis;

    initial begin
        vecs[0] = '{glyphs: {7'h7f, 7'b1111011, 7'b0100001, 7'b0100001, 7'b0001000}, offset: 5,
                    exp_pend: 1, exp_seg: {7'h7f, 7'b1111011, 7'b0100001, 7'b0100001, 7'b0001000}};
        vecs[1] = '{glyphs: {7'h7f, 7'h7f, 7'b0011000, 7'b0110000, 7'b1100000}, offset: 9,
                    exp_pend: 1, exp_seg: {7'h7f, 7'h7f, 7'b0011000, 7'b0110000, 7'b1100000}};
        vecs[2] = '{glyphs: {7'b1000000, 7'b1111001, 7'b1100000, 7'b1100011, 7'b0010010}, offset: 19,
                    exp_pend: 0, exp_seg: {7'b1000000, 7'b1111001, 7'b1100000, 7'b1100011, 7'b0010010}};
        g_lw  = {7'h7f, 7'h7f, 7'h7f, 7'b1010101, 7'b1000111};
        g_sw  = {7'h7f, 7'h7f, 7'h7f, 7'b1001001, 7'b0010010};
        g_dis = {7'b0000000, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0000110};

        // Reset dominates a simultaneous update.
        rst = 1; en = 1; upd = 1; seg_in = 35'({$urandom(), $urandom()});
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_an", o_an, 5'h1f);
            chk("rst_seg", o_seg, 7'h7f);
            chk("rst_pending", o_pending, 0);
            seg_in = 35'({$urandom(), $urandom()});
        end
        rst = 0; upd = 0;
        wait_fd();
        capture_frame("post_rst_blank", '1);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Two strobes before one commit: last one wins.
        wait_fd();
        repeat (2) cyc();
        seg_in = g_lw; upd = 1; cyc();
        upd = 0; repeat (3) cyc();
        seg_in = g_sw; upd = 1; cyc();
        upd = 0; seg_in = 35'({$urandom(), $urandom()});
        chk("lw_sw_pending", o_pending, 1);
        wait_fd();
        capture_frame("lw_sw", g_sw);

        // Disable mid-slot on digit 2 with data pending.
        wait_fd();
        repeat (3) cyc();
        seg_in = g_dis; upd = 1; cyc();
        upd = 0; seg_in = 35'({$urandom(), $urandom()});
        repeat (6) cyc();
        chk("dis_pre_an", o_an, 5'b11011);
        chk("dis_pre_pending", o_pending, 1);
        en = 0; cyc();
        chk("dis_an", o_an, 5'h1f);
        chk("dis_seg", o_seg, 7'h7f);
        chk("dis_pending", o_pending, 0);
        chk("dis_fd", o_frame_done, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("dis_hold_fd", o_frame_done, 0);
        end
        en = 1; cyc();
        chk("reen_guard_an", o_an, 5'h1f);
        cyc();
        chk("reen_an", o_an, 5'b11110);
        chk("reen_seg", o_seg, g_dis[0]);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 9) != 0);
            upd = ($urandom_range(0, 7) == 0);
            seg_in = 35'({$urandom(), $urandom()});
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
